// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: base+imm addressing, aligned B/H/W loads and stores, extended write-back
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [31:0] store_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        stall
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ISSUE    = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam logic [1:0] FINISH   = 2'd3;

    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    logic [1:0]  state;
    logic [31:0] ea_q;
    logic [31:0] sdata_q;
    logic [2:0]  f3_q;
    logic        store_q;
    logic [15:0] cnt;
    logic [31:0] wb_data_q;
    logic        fin_wb;
    logic        fin_mis;
    logic        fin_to;

    logic [31:0] ea_next;
    logic        req_illegal;
    logic        cnt_hit;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_result;

    assign ea_next = base + imm;
    assign cnt_hit = ({1'b0, cnt} + 17'd1) >= TIMEOUT_LIMIT;

    // Unknown width codes and "unsigned" stores are rejected alongside misalignment.
    always_comb begin
        req_illegal = 1'b0;
        case (funct3)
            3'b000, 3'b100: req_illegal = 1'b0;
            3'b001, 3'b101: req_illegal = ea_next[0];
            3'b010:         req_illegal = (ea_next[1:0] != 2'b00);
            default:        req_illegal = 1'b1;
        endcase
        if (req_is_store && funct3[2]) begin
            req_illegal = 1'b1;
        end
    end

    always_comb begin
        strb  = 4'b1111;
        wdata = sdata_q;
        case (f3_q[1:0])
            2'b00: begin
                strb  = 4'b0001 << ea_q[1:0];
                wdata = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                strb  = 4'b0011 << ea_q[1:0];
                wdata = {2{sdata_q[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = sdata_q;
            end
        endcase
    end

    always_comb begin
        rbyte = mem_rdata[7:0];
        case (ea_q[1:0])
            2'b00:   rbyte = mem_rdata[7:0];
            2'b01:   rbyte = mem_rdata[15:8];
            2'b10:   rbyte = mem_rdata[23:16];
            default: rbyte = mem_rdata[31:24];
        endcase
        rhalf = ea_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q[1:0])
            2'b00:   load_result = {{24{~f3_q[2] & rbyte[7]}}, rbyte};
            2'b01:   load_result = {{16{~f3_q[2] & rhalf[15]}}, rhalf};
            default: load_result = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ea_q      <= 32'd0;
            sdata_q   <= 32'd0;
            f3_q      <= 3'd0;
            store_q   <= 1'b0;
            cnt       <= 16'd0;
            wb_data_q <= 32'd0;
            fin_wb    <= 1'b0;
            fin_mis   <= 1'b0;
            fin_to    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fin_wb  <= 1'b0;
                    fin_mis <= 1'b0;
                    fin_to  <= 1'b0;
                    if (req_valid) begin
                        ea_q    <= ea_next;
                        sdata_q <= store_data;
                        f3_q    <= funct3;
                        store_q <= req_is_store;
                        if (req_illegal) begin
                            fin_mis <= 1'b1;
                            state   <= FINISH;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        if (store_q) begin
                            state <= FINISH;
                        end else begin
                            cnt   <= 16'd0;
                            state <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    // A response on the final counted cycle still wins over the timeout.
                    if (mem_rsp_valid) begin
                        wb_data_q <= load_result;
                        fin_wb    <= 1'b1;
                        state     <= FINISH;
                    end else if (cnt_hit) begin
                        wb_data_q <= 32'd0;
                        fin_to    <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    fin_wb  <= 1'b0;
                    fin_mis <= 1'b0;
                    fin_to  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (state == IDLE);
    assign stall         = (state != IDLE);
    assign mem_req_valid = (state == ISSUE);
    assign mem_addr      = mem_req_valid ? {ea_q[31:2], 2'b00} : 32'd0;
    assign mem_we        = mem_req_valid & store_q;
    assign mem_wstrb     = mem_we ? strb : 4'd0;
    assign mem_wdata     = mem_we ? wdata : 32'd0;
    assign done          = (state == FINISH);
    assign wb_valid      = done & fin_wb;
    assign err_misalign  = done & fin_mis;
    assign err_timeout   = done & fin_to;
    assign wb_data       = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit with cycle-level behavioural model
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] base = 32'd0;
    logic [31:0] imm = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        done;
    logic        err_misalign;
    logic        err_timeout;
    logic        stall;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .funct3(funct3), .base(base), .imm(imm),
        .store_data(store_data), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_data(wb_data), .done(done), .err_misalign(err_misalign),
        .err_timeout(err_timeout), .stall(stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic        e_req_ready, e_mem_req_valid, e_we, e_wb_valid, e_done, e_mis, e_to, e_stall;
    logic [31:0] e_addr, e_wdata, e_wb_data;
    logic [3:0]  e_wstrb;
    logic [31:0] model_wb = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_illegal(input bit st, input logic [2:0] f3, input logic [31:0] ea);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (st && f3 >= 3'd4) return 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) return (ea % 2) != 0;
        if (f3 == 3'd2) return (ea % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] rd);
        logic [31:0] v;
        int sh;
        case (f3)
            3'd0, 3'd4: begin
                sh = 8 * int'(ea % 4);
                v = (rd >> sh) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFFFF00;
            end
            3'd1, 3'd5: begin
                sh = ((ea % 4) >= 2) ? 16 : 0;
                v = (rd >> sh) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] ea);
        logic [3:0] one = 4'd1;
        logic [3:0] two = 4'd3;
        if (f3 == 3'd0) return one << (ea % 4);
        if (f3 == 3'd1) return two << (ea % 4);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3 == 3'd0) return (sd & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("req_ready", req_ready, e_req_ready);
            chk("mem_req_valid", mem_req_valid, e_mem_req_valid);
            if (e_mem_req_valid) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", mem_we, e_we);
                chk("mem_wstrb", mem_wstrb, e_wstrb);
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
            chk("wb_valid", wb_valid, e_wb_valid);
            chk("wb_data", wb_data, e_wb_data);
            chk("done", done, e_done);
            chk("err_misalign", err_misalign, e_mis);
            chk("err_timeout", err_timeout, e_to);
            chk("stall", stall, e_stall);
        end
    end

    task automatic set_idle();
        e_req_ready = 1'b1; e_mem_req_valid = 1'b0; e_we = 1'b0; e_wb_valid = 1'b0;
        e_done = 1'b0; e_mis = 1'b0; e_to = 1'b0; e_stall = 1'b0;
        e_addr = 32'd0; e_wdata = 32'd0; e_wstrb = 4'd0; e_wb_data = model_wb;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        set_idle();
        req_valid = 1'b0;
        mem_req_ready = 1'($urandom_range(0, 1));
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
    endtask

    // Called in an idle cycle; returns in the idle cycle following FINISH.
    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] b, input logic [31:0] i,
                          input logic [31:0] sd, input int rdy_dly, input int rsp_dly, input logic [31:0] rd);
        logic [31:0] ea;
        bit bad, ok, fin;
        int w;
        ea = b + i;
        bad = model_illegal(st, f3, ea);
        req_valid = 1'b1; req_is_store = st; funct3 = f3; base = b; imm = i; store_data = sd;
        next_cycle();
        if (!bad) begin
            for (int k = 0; k <= rdy_dly; k++) begin
                if (k > 0) next_cycle();
                e_req_ready = 1'b0; e_stall = 1'b1; e_mem_req_valid = 1'b1;
                e_addr = ea & 32'hFFFFFFFC; e_we = st;
                e_wstrb = st ? model_strb(f3, ea) : 4'd0;
                e_wdata = model_wdata(f3, sd);
                mem_req_ready = (k == rdy_dly);
                mem_rsp_valid = 1'b1;
            end
            next_cycle();
            if (!st) begin
                w = 0; fin = 1'b0; ok = 1'b0;
                while (!fin) begin
                    e_req_ready = 1'b0; e_stall = 1'b1;
                    if (w == rsp_dly) begin
                        mem_rsp_valid = 1'b1; mem_rdata = rd; ok = 1'b1; fin = 1'b1;
                    end else begin
                        mem_rsp_valid = 1'b0;
                        if (w + 1 >= TO) fin = 1'b1;
                    end
                    if (!fin) begin
                        next_cycle();
                        w++;
                    end
                end
                next_cycle();
                model_wb = ok ? model_load(f3, ea, rd) : 32'd0;
                e_wb_data = model_wb; e_wb_valid = ok; e_to = !ok;
            end
        end else begin
            e_mis = 1'b1;
        end
        e_req_ready = 1'b0; e_stall = 1'b1; e_done = 1'b1;
        // A request offered during FINISH must not be taken.
        req_valid = 1'b1; req_is_store = 1'($urandom_range(0, 1)); funct3 = 3'd2;
        base = $urandom & 32'hFFFFFFFC; imm = 32'd0;
        next_cycle();
    endtask

    initial begin
        logic [2:0] f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
        logic [31:0] b, i;
        #12;
        chk("rst_req_ready", req_ready, 32'd1);
        chk("rst_mem_req_valid", mem_req_valid, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_stall", stall, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        check_en = 1'b1;

        access(1'b0, 3'd0, 32'h1000, 32'hFFFFFFFF, 32'd0, 0, 0, 32'h80FF7F00);
        chk("model_lb_addr", (32'h1000 + 32'hFFFFFFFF) & 32'hFFFFFFFC, 32'h00000FFC);
        chk("model_lb", model_wb, 32'hFFFFFF80);
        chk("lit_lb", wb_data, 32'hFFFFFF80);
        access(1'b0, 3'd5, 32'h2000, 32'h2, 32'd0, 1, 1, 32'hBEEF1234);
        chk("lit_lhu", wb_data, 32'h0000BEEF);
        access(1'b0, 3'd1, 32'h2000, 32'h2, 32'd0, 0, 2, 32'hBEEF1234);
        chk("lit_lh", wb_data, 32'hFFFFBEEF);
        chk("model_sb_strb", model_strb(3'd0, 32'h3001), 32'h2);
        chk("model_sb_wdata", model_wdata(3'd0, 32'hA5), 32'hA5A5A5A5);
        access(1'b1, 3'd0, 32'h3000, 32'h1, 32'h000000A5, 3, 0, 32'd0);
        chk("lit_sb_keep_wb", wb_data, 32'hFFFFBEEF);
        access(1'b0, 3'd2, 32'h4000, 32'h2, 32'd0, 0, 0, 32'd0);
        access(1'b0, 3'd6, 32'h4000, 32'h0, 32'd0, 0, 0, 32'd0);
        access(1'b0, 3'd2, 32'h5000, 32'h4, 32'd0, 0, 3, 32'h12345678);
        chk("lit_boundary_rsp", wb_data, 32'h12345678);
        access(1'b0, 3'd2, 32'h5000, 32'h8, 32'd0, 0, 1000, 32'd0);
        chk("lit_timeout_wb", wb_data, 32'd0);

        // Reset asserted asynchronously in the middle of an ISSUE cycle.
        req_valid = 1'b1; req_is_store = 1'b1; funct3 = 3'd2; base = 32'h6000; imm = 32'd0;
        store_data = 32'hDEADBEEF;
        next_cycle();
        mem_req_ready = 1'b0;
        check_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 32'd1);
        chk("arst_mem_req_valid", mem_req_valid, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk("arst_mem_we", mem_we, 32'd0);
        chk("arst_mem_wstrb", mem_wstrb, 32'd0);
        chk("arst_mem_wdata", mem_wdata, 32'd0);
        chk("arst_done", done, 32'd0);
        chk("arst_wb_valid", wb_valid, 32'd0);
        chk("arst_errs", {err_misalign, err_timeout}, 32'd0);
        chk("arst_stall", stall, 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        model_wb = 32'd0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            check_en = 1'b1;
            mem_rsp_valid = 1'b1;
        end

        for (int n = 0; n < 300; n++) begin
            b = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFFFFFC);
            i = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
            access(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 7)], b, i, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 5), $urandom);
        end

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the immediate sign extender.
- Consumes the extended immediate and a base register value, and forms the effective address as base + imm.
- Performs aligned byte, half and word loads and stores over a valid/ready memory port, then returns sign- or zero-extended load data to write-back.
- Holds the core stalled while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting in WAIT_RSP before aborting (1..65535)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  access request from execute
req_ready  out  1  unit can accept a request
req_is_store  in  1  1 = store, 0 = load
funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
base  in  32  rs1 value
imm  in  32  extended immediate from sign extender
store_data  in  32  rs2 value
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  32  word-aligned address, effective address with bits [1:0] cleared
mem_we  out  1  1 = write
mem_wstrb  out  4  byte write enables
mem_wdata  out  32  lane-replicated write data
mem_rsp_valid  in  1  read data valid
mem_rdata  in  32  read data word
wb_valid  out  1  one-cycle pulse: wb_data valid
wb_data  out  32  extended load result
done  out  1  one-cycle pulse: access finished (load or store, success or error)
err_misalign  out  1  one-cycle pulse, coincident with done
err_timeout  out  1  one-cycle pulse, coincident with done
stall  out  1  high whenever state is not IDLE

Behaviour:
- Reset:
  - Async assertion forces state to IDLE from any state, including mid-access.
  - All outputs go to 0 except req_ready = 1.
  - The timeout counter clears.
  - mem_rsp_valid arriving after reset is ignored.
- FSM states are IDLE, ISSUE, WAIT_RSP and FINISH.
- IDLE:
  - req_ready = 1.
  - On req_valid, register ea = (base + imm) mod 2^32, together with funct3, req_is_store and store_data.
  - Alignment rules:
    - Byte is always aligned.
    - Half requires ea[0] = 0.
    - Word requires ea[1:0] = 0.
    - funct3 values 011, 110 and 111, and stores with funct3[2] = 1, are misaligned/illegal.
  - Illegal or misaligned request: go to FINISH with err_misalign set. No memory request is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req_valid = 1. mem_addr, mem_we, mem_wstrb and mem_wdata are held stable until mem_req_ready.
  - Write strobes:
    - Byte: 0001 << ea[1:0].
    - Half: 0011 << ea[1:0].
    - Word: 1111.
  - Write data:
    - Byte: store_data[7:0] replicated x4.
    - Half: store_data[15:0] replicated x2.
    - Word: unchanged.
  - For loads, mem_we = 0 and mem_wstrb = 0.
  - On mem_req_ready: a store goes to FINISH (posted write, no response expected); a load goes to WAIT_RSP with the counter cleared.
  - mem_rsp_valid is ignored in ISSUE.
- WAIT_RSP:
  - The counter increments each cycle without mem_rsp_valid.
  - On mem_rsp_valid, select the lane by ea[1:0] (byte) or ea[1] (half).
  - Extension: sign-extend when funct3[2] = 0, zero-extend when funct3[2] = 1. Word passes through.
  - Register the result into wb_data and go to FINISH with wb_valid set.
  - If the counter reaches TIMEOUT_CYCLES without a response, go to FINISH with err_timeout set and wb_data = 0.
  - A response arriving in the same cycle the counter reaches TIMEOUT_CYCLES takes priority, and the load succeeds.
- FINISH:
  - Lasts exactly one cycle.
  - done = 1, plus whichever of wb_valid, err_misalign or err_timeout applies.
  - Returns to IDLE. req_ready is 0 in this cycle, so there is no back-to-back accept.
- Latency with zero-wait memory:
  - Load: accept at edge 0, mem_req_valid in cycle 1; response in cycle 2 gives wb_valid in cycle 3.
  - Store: accept at edge 0, done in cycle 2.
  - Misaligned: accept at edge 0, done in cycle 1.
- wb_data holds its value until the next successful load. err_timeout forces it to 0.
- stall = (state != IDLE).

Test Plan:
- LB sign: base = 0x1000, imm = 0xFFFFFFFF (−1), funct3 = 000, mem_rdata = 0x80FF7F00 → mem_addr = 0x00000FFC, lane 3, wb_data = 0xFFFFFF80, wb_valid 1 cycle, done coincident.
- LHU: ea = 0x2002, mem_rdata = 0xBEEF1234 → wb_data = 0x0000BEEF; with LH → 0xFFFFBEEF.
- SB: ea = 0x3001, store_data = 0x000000A5 with mem_req_ready held low 3 cycles → mem_req_valid and outputs stable for 4 cycles, mem_wstrb = 0010, mem_wdata = 0xA5A5A5A5, done 1 cycle after handshake, no wb_valid.
- Misaligned LW at ea = 0x4002, and funct3 = 110 → no mem_req_valid, err_misalign and done in cycle 1, stall high for exactly 1 cycle.
- Timeout: TIMEOUT_CYCLES = 4, LW with mem_rsp_valid never asserted → err_timeout and done after 4 WAIT_RSP cycles, wb_data = 0; then rst_n pulsed low in the middle of a subsequent ISSUE → all outputs 0 immediately, req_ready = 1.
